// File: rtl/branch_target_loader.sv
// Runtime-loadable branch-offset table for the fetch stage.
// Byte-serial valid/ready load port, combinational read port.
module branch_target_loader #(
  parameter int D     = 12,
  parameter int N_ENT = 64
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic [5:0]   rd_addr,
  output logic [D-1:0] rd_target,
  output logic         rd_hit,
  output logic         err,
  output logic [6:0]   wr_count,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CLEAR
  } state_t;

  state_t state, state_n;

  logic [D-1:0]     mem [N_ENT];
  logic [N_ENT-1:0] valid;
  logic [5:0]       idx_q;
  logic [7:0]       hi_q;

  logic        beat;
  logic [15:0] payload;
  logic        fits;
  logic        ld_idx;
  logic        ld_hi;
  logic        do_wr;
  logic        do_err;
  logic        do_clr;

  assign in_ready = (state != S_CLEAR);
  assign busy     = (state != S_IDLE);
  assign beat     = in_valid && in_ready;
  assign payload  = {hi_q, in_data};

  // Upper bits all-ones or all-zeros means the value sign-extends from D bits.
  assign fits = (&payload[15:D-1]) | ~(|payload[15:D-1]);

  assign rd_hit    = valid[rd_addr];
  assign rd_target = valid[rd_addr] ? mem[rd_addr] : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ld_idx  = 1'b0;
    ld_hi   = 1'b0;
    do_wr   = 1'b0;
    do_err  = 1'b0;
    do_clr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (beat) begin
          if (in_data[7]) begin
            state_n = S_CLEAR;
          end else begin
            ld_idx  = 1'b1;
            state_n = S_HI;
          end
        end
      end
      S_HI: begin
        if (beat) begin
          ld_hi   = 1'b1;
          state_n = S_LO;
        end
      end
      S_LO: begin
        if (beat) begin
          do_wr   = fits;
          do_err  = !fits;
          state_n = S_IDLE;
        end
      end
      S_CLEAR: begin
        do_clr  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q <= '0;
      hi_q  <= '0;
    end else begin
      if (ld_idx) idx_q <= in_data[5:0];
      if (ld_hi)  hi_q  <= in_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_ENT; i++) mem[i] <= '0;
      valid    <= '0;
      err      <= 1'b0;
      wr_count <= '0;
    end else if (do_clr) begin
      for (int i = 0; i < N_ENT; i++) mem[i] <= '0;
      valid    <= '0;
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      if (do_wr) begin
        mem[idx_q]   <= payload[D-1:0];
        valid[idx_q] <= 1'b1;
        if (wr_count != 7'd127) wr_count <= wr_count + 7'd1;
      end
      if (do_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_target_loader.sv
// Randomized bench for branch_target_loader against a
// record-level reference model.
module tb_branch_target_loader;

  localparam int D = 12;

  logic         Clk;
  logic         Reset_n;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [5:0]   rd_addr;
  logic [D-1:0] rd_target;
  logic         rd_hit;
  logic         err;
  logic [6:0]   wr_count;
  logic         busy;

  branch_target_loader #(.D(D), .N_ENT(64)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_addr   (rd_addr),
    .rd_target (rd_target),
    .rd_hit    (rd_hit),
    .err       (err),
    .wr_count  (wr_count),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int       m_mem [64];
  bit       m_valid [64];
  int       m_cnt;
  bit       m_err;
  bit       m_clr;
  bit [7:0] rec [$];
  bit       last_beat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] tr(input int v);
    return v[D-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_mem[i]   = 0;
      m_valid[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_beat(input bit [7:0] b);
    int p;
    rec.push_back(b);
    if (rec.size() == 1 && rec[0][7]) begin
      m_clr = 1'b1;
      rec.delete();
    end else if (rec.size() == 3) begin
      p = int'($signed({rec[1], rec[2]}));
      if (p >= -(1 << (D - 1)) && p < (1 << (D - 1))) begin
        m_mem[rec[0][5:0]]   = p;
        m_valid[rec[0][5:0]] = 1'b1;
        if (m_cnt < 127) m_cnt++;
      end else begin
        m_err = 1'b1;
      end
      rec.delete();
    end
  endtask

  task automatic step();
    bit       beat;
    bit [7:0] b;
    @(negedge Clk);
    chk("in_ready", in_ready, !m_clr);
    chk("busy", busy, m_clr || rec.size() != 0);
    chk("rd_hit", rd_hit, m_valid[rd_addr]);
    chk("rd_target", rd_target,
        m_valid[rd_addr] ? tr(m_mem[rd_addr]) : '0);
    chk("err", err, m_err);
    chk("wr_count", wr_count, m_cnt);
    beat = in_valid && !m_clr;
    b    = in_data;
    @(posedge Clk);
    last_beat = 1'b0;
    if (Reset_n) begin
      if (m_clr) begin
        model_clear();
        m_clr = 1'b0;
      end else if (beat) begin
        model_beat(b);
        last_beat = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_clear();
    m_clr = 1'b0;
    rec.delete();
    step();
    Reset_n = 1'b1;
  endtask

  task automatic send(input bit [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 8 && !ok; n++) begin
      step();
      ok = last_beat;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  function automatic bit [7:0] gen();
    bit [7:0] r = 8'($urandom);
    if (rec.size() == 0)
      return ($urandom_range(0, 15) == 0) ? (r | 8'h80) : (r & 8'h7F);
    if (rec.size() == 1) begin
      unique case ($urandom_range(0, 4))
        0: return 8'h00;
        1: return 8'hFF;
        2: return 8'h07;
        3: return 8'hF8;
        default: return r;
      endcase
    end
    return r;
  endfunction

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 6'd0;
    m_clr    = 1'b0;
    do_reset();

    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      step();
    end
    chk("rst_wr_count", wr_count, 0);

    send(8'h02);
    chk("busy_idx", busy, 1);
    send(8'hFF);
    send(8'hEF);
    chk("busy_lo", busy, 0);
    rd_addr = 6'd2;
    step();
    chk("e2_target", rd_target, 12'hFEF);
    chk("e2_hit", rd_hit, 1);
    chk("e2_count", wr_count, 1);

    send(8'h05);
    send(8'h08);
    send(8'h00);
    rd_addr = 6'd5;
    step();
    chk("oor_err", err, 1);
    chk("oor_hit", rd_hit, 0);
    chk("oor_target", rd_target, 0);
    chk("oor_count", wr_count, 1);

    send(8'h80);
    chk("clr_ready", in_ready, 0);
    chk("clr_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 8'h03;
    step();
    chk("clr_held_wait", last_beat, 0);
    chk("clr_err", err, 0);
    chk("clr_count", wr_count, 0);
    step();
    chk("clr_held_take", last_beat, 1);
    in_valid = 1'b0;
    send(8'h00);
    send(8'h07);
    rd_addr = 6'd3;
    step();
    chk("held_e3", rd_target, 7);
    chk("held_count", wr_count, 1);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      step();
    end

    send(8'h11);
    send(8'h00);
    do_reset();
    send(8'h11);
    send(8'hFF);
    send(8'h71);
    rd_addr = 6'd17;
    step();
    chk("rst_e17", rd_target, 12'hF71);
    chk("rst_count", wr_count, 1);

    send(8'h80);
    step();
    send(8'h20);
    send(8'h00);
    rd_addr = 6'h20;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_nohit", rd_hit, 0);
    end
    send(8'h01);
    step();
    chk("stall_e32", rd_target, 1);
    send(8'h80);
    step();
    send(8'h00); send(8'h00); send(8'h0B);
    send(8'h00); send(8'h00); send(8'h0F);
    rd_addr = 6'd0;
    step();
    chk("rw_e0", rd_target, 15);
    chk("rw_count", wr_count, 2);

    for (int i = 0; i < 130; i++) begin
      send(8'(i % 64));
      send(8'h00);
      send(8'(i));
    end
    step();
    chk("sat_count", wr_count, 127);

    for (int i = 0; i < 3000; i++) begin
      rd_addr = 6'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        in_valid = 1'b0;
        do_reset();
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = gen();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
